// File: rtl/mem_responder_pkg.sv
// Memory request/response message layout shared by the core ports and the test responder.
// Field offsets, type/len encodings and byte-lane helpers.
package mem_responder_pkg;

    localparam int MEMREQ_MSG_BITS  = 67;
    localparam int MEMRESP_MSG_BITS = 35;

    localparam int REQ_TYPE_BIT  = 66;
    localparam int REQ_ADDR_LSB  = 34;
    localparam int REQ_LEN_LSB   = 32;
    localparam int REQ_DATA_LSB  = 0;

    localparam int RESP_TYPE_BIT = 34;
    localparam int RESP_LEN_LSB  = 32;
    localparam int RESP_DATA_LSB = 0;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_e;

    typedef enum logic [1:0] {
        LEN_WORD = 2'd0,
        LEN_BYTE = 2'd1,
        LEN_HALF = 2'd2,
        LEN_RSVD = 2'd3
    } mem_len_e;

    typedef struct packed {
        mem_type_e   typ;
        logic [31:0] addr;
        mem_len_e    len;
        logic [31:0] data;
    } memreq_t;

    typedef struct packed {
        mem_type_e   typ;
        mem_len_e    len;
        logic [31:0] data;
    } memresp_t;

    // Lowest byte lane touched; the reserved len behaves as a full word.
    function automatic logic [1:0] lane_offset(mem_len_e len, logic [1:0] a);
        logic [1:0] off;
        off = 2'b00;
        case (len)
            LEN_BYTE: off = a;
            LEN_HALF: off = {a[1], 1'b0};
            default:  off = 2'b00;
        endcase
        return off;
    endfunction

    function automatic logic [3:0] lane_mask(mem_len_e len, logic [1:0] a);
        logic [3:0] m;
        m = 4'b1111;
        case (len)
            LEN_BYTE: m = 4'b0001 << a;
            LEN_HALF: m = 4'b0011 << {a[1], 1'b0};
            default:  m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] size_mask(mem_len_e len);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        case (len)
            LEN_BYTE: m = 32'h0000_00FF;
            LEN_HALF: m = 32'h0000_FFFF;
            default:  m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_resp_delay_pipe.sv
// Fixed-depth valid/message delay line with synchronous clear.
// A stage's message only moves when its valid bit does, so the output holds between responses.
module mem_resp_delay_pipe #(
    parameter int LATENCY  = 2,
    parameter int MSG_BITS = 35
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                in_val,
    input  logic [MSG_BITS-1:0] in_msg,
    output logic                out_val,
    output logic [MSG_BITS-1:0] out_msg
);

    logic [LATENCY-1:0]  val_q;
    logic [MSG_BITS-1:0] msg_q [LATENCY];

    always_ff @(posedge clk) begin
        if (clear) begin
            val_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                msg_q[i] <= '0;
            end
        end else begin
            val_q[0] <= in_val;
            if (in_val) begin
                msg_q[0] <= in_msg;
            end
            for (int i = 1; i < LATENCY; i++) begin
                val_q[i] <= val_q[i-1];
                if (val_q[i-1]) begin
                    msg_q[i] <= msg_q[i-1];
                end
            end
        end
    end

    assign out_val = val_q[LATENCY-1];
    assign out_msg = msg_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-port test memory answering the core's memory request protocol.
// Optional MEM_STALL_EN adds LFSR-driven backpressure on memreq_rdy.
import mem_responder_pkg::*;

module mem_responder #(
    parameter int         ADDR_BITS = 12,
    parameter int         LATENCY   = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MEMREQ_MSG_BITS-1:0]  memreq_msg,
    input  logic                        memreq_val,
    output logic                        memreq_rdy,
    output logic [MEMRESP_MSG_BITS-1:0] memresp_msg,
    output logic                        memresp_val
);

    localparam int WORDS = 2 ** ADDR_BITS;

    logic [31:0] mem [WORDS];

    memreq_t              req;
    memresp_t             resp_in;
    logic                 accept;
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           off;
    logic [4:0]           shamt;
    logic [3:0]           wmask;
    logic [31:0]          wdata;
    logic [31:0]          rd_word;
    logic [31:0]          rd_data;
    logic [31-ADDR_BITS-2:0] unused_addr_hi;

    assign req            = memreq_t'(memreq_msg);
    assign accept         = memreq_val && memreq_rdy;
    assign word_idx       = req.addr[ADDR_BITS+1:2];
    assign unused_addr_hi = req.addr[31:ADDR_BITS+2];

    assign off   = lane_offset(req.len, req.addr[1:0]);
    assign shamt = {off, 3'b000};
    assign wmask = lane_mask(req.len, req.addr[1:0]);
    assign wdata = req.data << shamt;

    // Asynchronous read so a read right after a write sees the new word.
    assign rd_word = mem[word_idx];
    assign rd_data = (rd_word >> shamt) & size_mask(req.len);

    always_ff @(posedge clk) begin
        if (accept && req.typ == MEM_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        resp_in      = '0;
        resp_in.typ  = req.typ;
        resp_in.len  = req.len;
        resp_in.data = (req.typ == MEM_WRITE) ? 32'h0 : rd_data;
    end

    mem_resp_delay_pipe #(
        .LATENCY  (LATENCY),
        .MSG_BITS (MEMRESP_MSG_BITS)
    ) u_pipe (
        .clk     (clk),
        .clear   (reset),
        .in_val  (accept),
        .in_msg  (resp_in),
        .out_val (memresp_val),
        .out_msg (memresp_msg)
    );

`ifdef MEM_STALL_EN
    logic [7:0] lfsr_q;

    // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0],
                       lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign memreq_rdy = ~reset && (lfsr_q[1:0] != 2'b00);
`else
    logic [7:0] unused_lfsr_seed;

    assign unused_lfsr_seed = LFSR_SEED;
    assign memreq_rdy       = ~reset;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases plus random traffic
// compared against a byte-array reference model; honours MEM_STALL_EN.
module tb_mem_responder;

    localparam int         LAT   = 2;
    localparam int         AB    = 12;
    localparam int         WORDS = 2 ** AB;
    localparam logic [7:0] SEED  = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [66:0] memreq_msg;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [34:0] memresp_msg;
    logic        memresp_val;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [34:0] msg;
        int          due;
    } exp_t;

    typedef struct {
        logic [34:0] msg;
        int          cyc;
    } obs_t;

    logic [7:0] mb [4*WORDS];
    exp_t       exp_q [$];
    obs_t       obs_q [$];
    int         acc_q [$];
    int         k = 0;
    bit         init = 1'b0;
    logic [34:0] hold_msg;
    logic [7:0]  lfsr_m;

    mem_responder #(
        .ADDR_BITS (AB),
        .LATENCY   (LAT),
        .LFSR_SEED (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: little-endian byte array, lanes picked by size and address.
    function automatic logic [34:0] model_req(input logic [66:0] m);
        logic        typ;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [31:0] rd;
        int          n;
        int          base;
        int          start;
        typ  = m[66];
        addr = m[65:34];
        len  = m[33:32];
        data = m[31:0];
        n    = (len == 2'd1) ? 1 : (len == 2'd2) ? 2 : 4;
        base = (int'(addr >> 2) % WORDS) * 4;
        if (n == 4)      start = 0;
        else if (n == 2) start = int'(addr[1:0]) & 2;
        else             start = int'(addr[1:0]);
        rd = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (typ) mb[base+start+i] = data[8*i +: 8];
            else     rd = rd | (32'(mb[base+start+i]) << (8*i));
        end
        return {typ, len, typ ? 32'h0 : rd};
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    always @(negedge clk) begin
        logic exp_rdy;
`ifdef MEM_STALL_EN
        exp_rdy = !reset && (lfsr_m[1:0] != 2'b00);
`else
        exp_rdy = !reset;
`endif
        if (init) begin
            chk("rdy", memreq_rdy, exp_rdy);
            if (exp_q.size() > 0 && exp_q[0].due == k) begin
                chk("resp_val", memresp_val, 1'b1);
                chk("resp_msg", memresp_msg, exp_q[0].msg);
                hold_msg = exp_q[0].msg;
                void'(exp_q.pop_front());
            end else begin
                chk("idle_val", memresp_val, 1'b0);
                chk("hold_msg", memresp_msg, hold_msg);
            end
            if (memresp_val === 1'b1) begin
                obs_q.push_back('{msg: memresp_msg, cyc: k});
            end
            if (!reset && memreq_val && memreq_rdy) begin
                acc_q.push_back(k);
                exp_q.push_back('{msg: model_req(memreq_msg), due: k + LAT});
            end
        end
        if (reset) begin
            exp_q.delete();
            hold_msg = '0;
            init     = 1'b1;
        end
        lfsr_m = reset ? SEED : {lfsr_m[6:0], ^(lfsr_m & 8'b1011_1000)};
        k++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic typ, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data);
        int b;
        memreq_msg = {typ, addr, len, data};
        memreq_val = 1'b1;
        b = 0;
        forever begin
            @(negedge clk);
            if (memreq_rdy) break;
            b++;
            if (b > 50) begin
                chk("rdy_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        memreq_val = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] exp_rd [10];
        reset      = 1'b1;
        memreq_val = 1'b0;
        memreq_msg = '0;
        for (int i = 0; i < WORDS; i++) begin
            w = $urandom;
            if (i == 4) w = 32'hDEAD_BEEF;
            if (i == 8) w = 32'h1122_3344;
            dut.mem[i] = w;
            {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]} = w;
        end
        idle(3);
        chk("reset_rdy", memreq_rdy, 1'b0);
        chk("reset_val", memresp_val, 1'b0);
        chk("reset_msg", memresp_msg, 35'h0);
        reset = 1'b0;
        idle(2);

        // Word read with fixed latency.
        obs_q.delete();
        acc_q.delete();
        send(1'b0, 32'h10, 2'd0, 32'h0);
        idle(LAT + 3);
        chk("rd_word_count", obs_q.size(), 1);
        chk("rd_word_msg", obs_q[0].msg, {1'b0, 2'd0, 32'hDEAD_BEEF});
        chk("rd_word_lat", obs_q[0].cyc - acc_q[0], LAT);

        // Byte write then read-after-write.
        obs_q.delete();
        send(1'b1, 32'h21, 2'd1, 32'h0000_00AB);
        send(1'b0, 32'h20, 2'd0, 32'h0);
        idle(LAT + 3);
        chk("wr_byte_count", obs_q.size(), 2);
        chk("wr_byte_resp", obs_q[0].msg, {1'b1, 2'd1, 32'h0});
        chk("raw_word", obs_q[1].msg, {1'b0, 2'd0, 32'h1122_AB44});

        // Halfword/byte extraction, addr[0] ignored for halfwords.
        obs_q.delete();
        send(1'b1, 32'h10, 2'd0, 32'hCAFE_F00D);
        send(1'b0, 32'h12, 2'd2, 32'h0);
        send(1'b0, 32'h13, 2'd1, 32'h0);
        send(1'b0, 32'h13, 2'd2, 32'h0);
        send(1'b0, 32'h10, 2'd1, 32'h0);
        send(1'b0, 32'h4010, 2'd3, 32'h0);
        idle(LAT + 3);
        chk("lane_count", obs_q.size(), 6);
        chk("rd_half_hi", obs_q[1].msg, {1'b0, 2'd2, 32'h0000_CAFE});
        chk("rd_byte_3", obs_q[2].msg, {1'b0, 2'd1, 32'h0000_00CA});
        chk("rd_half_odd", obs_q[3].msg, {1'b0, 2'd2, 32'h0000_CAFE});
        chk("rd_byte_0", obs_q[4].msg, {1'b0, 2'd1, 32'h0000_000D});
        chk("rd_wrap_rsvd", obs_q[5].msg, {1'b0, 2'd3, 32'hCAFE_F00D});

        // Back-to-back reads of consecutive words.
        obs_q.delete();
        for (int i = 0; i < 10; i++) exp_rd[i] = model_word(64 + i);
        for (int i = 0; i < 10; i++) send(1'b0, 32'h100 + 32'(4*i), 2'd0, 32'h0);
        idle(LAT + 3);
        chk("b2b_count", obs_q.size(), 10);
        for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
            chk("b2b_data", obs_q[i].msg, {1'b0, 2'd0, exp_rd[i]});
`ifndef MEM_STALL_EN
            chk("b2b_cycle", obs_q[i].cyc - obs_q[0].cyc, i);
`endif
        end

        // Reset with reads in flight.
        send(1'b0, 32'h100, 2'd0, 32'h0);
        send(1'b0, 32'h104, 2'd0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("rst_rdy", memreq_rdy, 1'b0);
            chk("rst_val", memresp_val, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", memreq_rdy, 1'b1);
        chk("post_rst_val", memresp_val, 1'b0);
        chk("post_rst_msg", memresp_msg, 35'h0);
        idle(1);

        // Random traffic over a small window with aliased high bits.
        for (int n = 0; n < 200; n++) begin
            send(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_C0FF,
                 2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(LAT + 4);
        chk("all_delivered", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-port, fixed-latency test memory; the responder end of the 32-bit-address / 32-bit-data memory request/response protocol driven by the core's imem and dmem ports.
- Accepts request messages under a val/rdy handshake and performs the byte-addressed read or write.
- Returns one response message per accepted request, in order, LATENCY cycles later.
- Response side has val only; the core always accepts. Two instances (imem, dmem) sit beside the core in the test harness.

Parameters:
- ADDR_BITS, 12: word-index width; memory holds 2^ADDR_BITS 32-bit words.
- LATENCY, 2: cycles from request accept to response valid; legal range 1..8.
- LFSR_SEED, 8'hA5: reset value of the stall LFSR (used only with MEM_STALL_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- memreq_msg  in  67  request: [66] type (0=read, 1=write), [65:34] addr, [33:32] len, [31:0] data
- memreq_val  in  1  request valid
- memreq_rdy  out  1  request ready
- memresp_msg  out  35  response: [34] type, [33:32] len, [31:0] data
- memresp_val  out  1  response valid; no ready, consumer always accepts

Behaviour:
- Interface: one clock, clk; reset is synchronous, active-high, on port reset.
- Reset values: memreq_rdy=0 while reset is high; memresp_val=0; memresp_msg=0; all pipeline valid bits cleared.
- Memory array is not reset; the bench preloads it hierarchically.
- Accept: on a rising edge with memreq_val && memreq_rdy.
- Addressing: word index = addr[ADDR_BITS+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory size.
- len encoding: 0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes, 3 = reserved and treated as 4 bytes.
- Byte lanes, little-endian:
  - byte access uses lane addr[1:0];
  - halfword access uses lanes {addr[1],0} and {addr[1],1}, with addr[0] ignored;
  - word access ignores addr[1:0].
- Write: the selected bytes, taken from the low bytes of data, update the array in the accept cycle. Response data=0, type=1, len echoed.
- Read: the array is sampled in the accept cycle. The selected bytes are right-aligned and zero-extended (sign extension belongs to the requester). type=0, len echoed.
- Ordering: strictly in order. A read accepted the cycle after a write to the same word returns the new data. Single port, so simultaneous requests are impossible.
- Latency: the response for a request accepted at edge N has memresp_val=1 during the cycle following edge N+LATENCY-1.
  - LATENCY=1: the response appears the cycle after accept.
  - Back-to-back accepts give back-to-back responses, one per cycle.
- Delay pipeline: LATENCY stages of {val, 35-bit msg}. Shifts every cycle; there is no stall, because the response side has no ready.
- memreq_rdy: 1 every non-reset cycle, unless MEM_STALL_EN applies.
- Reset mid-operation: all in-flight responses are dropped. Writes already accepted remain in the array.
- memresp_msg holds its last value while memresp_val=0. The content is don't-care; the implementation keeps it stable.

Optional Feature:
- MEM_STALL_EN defined:
  - an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) loads LFSR_SEED on reset and advances every cycle;
  - memreq_rdy = ~reset && (lfsr[1:0] != 2'b00), i.e. about 25% backpressure;
  - latency from accept is unchanged.
- MEM_STALL_EN undefined: no LFSR is built; memreq_rdy = ~reset.

Decomposition:
- Shared header (the existing mem message include) supplies:
  - message size macros;
  - field offsets for type, addr, len and data;
  - type encodings READ=0 and WRITE=1;
  - len encodings.
- The block adds no new package.
- One natural sub-module: mem_resp_delay_pipe, a parameterised LATENCY-deep valid/message shift register with synchronous clear.
- Byte-lane extract/merge stays inline.

Test Plan:
- LATENCY=2, preload word[4]=32'hDEADBEEF; read addr 0x10, len 0 accepted at cycle 5 -> memresp_val=1 in cycle 7, memresp_msg={0,2'd0,32'hDEADBEEF}.
- Write addr 0x21, len 1, data 0x000000AB to a word holding 0x11223344, then read word 0x20 -> write response {1,2'd1,0}; read returns 0x1122AB44.
- Read halfword addr 0x12 from word 0xCAFEF00D, then byte addr 0x13 -> 0x0000CAFE, then 0x000000CA.
- Ten back-to-back reads of consecutive words, LATENCY=3 -> ten consecutive memresp_val cycles, in address order, first one three cycles after the first accept.
- Assert reset while two reads are in flight -> memresp_val stays 0 through reset and after it; memreq_rdy=0 during reset and 1 the cycle after (stall feature off).
- MEM_STALL_EN, LFSR_SEED=8'hA5, 200 random requests -> memreq_rdy pattern matches the LFSR model; every accepted request gets exactly one correct response at the fixed LATENCY.
